scoreboard_regfile: RTL and testbench

- Next-generation integer register file for the RISC-V core.
- Generalises the current 2-read/1-write file to N read ports, an optional hardwired zero register and an optional write-to-read bypass.
- Adds a per-register pending (scoreboard) bit and a pending-register counter so the issue stage can detect RAW and WAW hazards.
- Sits between decode/issue (reads, reservations) and writeback (writes).

---
 rtl/scoreboard_regfile_if.sv | 31 +++
 rtl/scoreboard_regfile.sv | 81 ++++++++
 tb/tb_scoreboard_regfile.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_regfile_if.sv
// Register-file bus bundle: read ports, writeback, reservations and the pending count.
// The master side is the issue/writeback logic and the slave side is the register file.
interface scoreboard_regfile_if #(
    parameter int DEPTH      = 32,
    parameter int BITS       = 64,
    parameter int READ_PORTS = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [READ_PORTS*AW-1:0]   readAddr;
    logic [READ_PORTS*BITS-1:0] readData;
    logic [READ_PORTS-1:0]      readBusy;
    logic                       writeEn;
    logic [AW-1:0]              writeAddr;
    logic [BITS-1:0]            writeData;
    logic                       reserveEn;
    logic [AW-1:0]              reserveAddr;
    logic                       reserveReady;
    logic                       flush;
    logic [AW:0]                pendingCount;

    modport master (
        output readAddr, writeEn, writeAddr, writeData, reserveEn, reserveAddr, flush,
        input  readData, readBusy, reserveReady, pendingCount
    );

    modport slave (
        input  readAddr, writeEn, writeAddr, writeData, reserveEn, reserveAddr, flush,
        output readData, readBusy, reserveReady, pendingCount
    );
endinterface

// File: rtl/scoreboard_regfile.sv
// Integer register file with N read ports, optional zero register and write bypass,
// plus a per-register pending scoreboard and a running count of pending registers.
module scoreboard_regfile #(
    parameter int DEPTH      = 32,
    parameter int BITS       = 64,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input logic                clk,
    input logic                rst_n,
    scoreboard_regfile_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [BITS-1:0]  regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [AW:0]      count;

    logic write_hit;
    logic write_clears;
    logic reserve_ready;
    logic reserve_set;

    // Gating with rst_n keeps the bypass from leaking writeData while reset is held.
    assign write_hit     = rst_n && bus.writeEn && !(ZERO_REG != 0 && bus.writeAddr == '0);
    assign write_clears  = write_hit && pending[bus.writeAddr];
    assign reserve_ready = bus.reserveEn && !pending[bus.reserveAddr] && !bus.flush;
    assign reserve_set   = reserve_ready && !(ZERO_REG != 0 && bus.reserveAddr == '0);

    assign bus.reserveReady = reserve_ready;
    assign bus.pendingCount = count;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = bus.readAddr[p*AW +: AW];
        assign hit  = (BYPASS != 0) && write_hit && (bus.writeAddr == addr);
        assign bus.readData[p*BITS +: BITS] = hit ? bus.writeData : regs[addr];
        assign bus.readBusy[p]              = !hit && pending[addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[bus.writeAddr] <= bus.writeData;
        end
    end

    // The reserve is applied after the write clear so a new owner keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (bus.flush) begin
            pending <= '0;
        end else begin
            if (write_hit) begin
                pending[bus.writeAddr] <= 1'b0;
            end
            if (reserve_set) begin
                pending[bus.reserveAddr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (bus.flush) begin
            count <= '0;
        end else if (reserve_set && !write_clears) begin
            count <= count + (AW+1)'(1);
        end else if (!reserve_set && write_clears) begin
            count <= count - (AW+1)'(1);
        end
    end
endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench: a vector table on the default configuration, then hand-written
// sequences on a narrow no-bypass instance and a mid-cycle asynchronous reset.
module tb_scoreboard_regfile;
    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #50 clk = ~clk;

    int checks = 0;
    int errors = 0;

    scoreboard_regfile_if #(.DEPTH(32), .BITS(64), .READ_PORTS(2)) busA ();
    scoreboard_regfile_if #(.DEPTH(16), .BITS(32), .READ_PORTS(3)) busB ();

    scoreboard_regfile #(.DEPTH(32), .BITS(64), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(1)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA)
    );
    scoreboard_regfile #(.DEPTH(16), .BITS(32), .READ_PORTS(3), .ZERO_REG(1), .BYPASS(0)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB)
    );

    typedef struct {
        string       name;
        int          ra0;
        int          ra1;
        bit          we;
        int          wa;
        logic [63:0] wd;
        bit          re;
        int          rsa;
        bit          fl;
        logic [63:0] d0;
        bit          b0;
        logic [63:0] d1;
        bit          b1;
        bit          rdy;
        int          cnt;
        bit          inv;
    } vec_t;

    vec_t vecs [19];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleA();
        busA.readAddr    = '0;
        busA.writeEn     = 1'b0;
        busA.writeAddr   = '0;
        busA.writeData   = '0;
        busA.reserveEn   = 1'b0;
        busA.reserveAddr = '0;
        busA.flush       = 1'b0;
    endtask

    task automatic idleB();
        busB.readAddr    = '0;
        busB.writeEn     = 1'b0;
        busB.writeAddr   = '0;
        busB.writeData   = '0;
        busB.reserveEn   = 1'b0;
        busB.reserveAddr = '0;
        busB.flush       = 1'b0;
    endtask

    // Combinational outputs are checked mid-low-phase, the counter just after the edge.
    task automatic applyStimulus(input vec_t v);
        int busyCount;
        @(negedge clk);
        busA.readAddr    = {v.ra1[4:0], v.ra0[4:0]};
        busA.writeEn     = v.we;
        busA.writeAddr   = v.wa[4:0];
        busA.writeData   = v.wd;
        busA.reserveEn   = v.re;
        busA.reserveAddr = v.rsa[4:0];
        busA.flush       = v.fl;
        #1;
        checkOutput({v.name, "/data0"}, busA.readData[63:0], v.d0);
        checkOutput({v.name, "/busy0"}, 64'(busA.readBusy[0]), 64'(v.b0));
        checkOutput({v.name, "/data1"}, busA.readData[127:64], v.d1);
        checkOutput({v.name, "/busy1"}, 64'(busA.readBusy[1]), 64'(v.b1));
        checkOutput({v.name, "/ready"}, 64'(busA.reserveReady), 64'(v.rdy));
        @(posedge clk);
        #1;
        checkOutput({v.name, "/count"}, 64'(busA.pendingCount), 64'(v.cnt));
        idleA();
        if (v.inv) begin
            busyCount = 0;
            for (int a = 0; a < 32; a++) begin
                busA.readAddr = {5'd0, 5'(a)};
                #1;
                busyCount += int'(busA.readBusy[0]);
            end
            checkOutput({v.name, "/popcount"}, 64'(busyCount), 64'(v.cnt));
            busA.readAddr = '0;
        end
    endtask

    task automatic applyStimulusB(input string name, input int ra0, input int ra1, input int ra2,
                                  input bit we, input int wa, input logic [31:0] wd,
                                  input bit re, input int rsa, input bit fl,
                                  input logic [31:0] d0, input bit b0,
                                  input logic [31:0] d2, input bit b2,
                                  input bit rdy, input int cnt);
        @(negedge clk);
        busB.readAddr    = {ra2[3:0], ra1[3:0], ra0[3:0]};
        busB.writeEn     = we;
        busB.writeAddr   = wa[3:0];
        busB.writeData   = wd;
        busB.reserveEn   = re;
        busB.reserveAddr = rsa[3:0];
        busB.flush       = fl;
        #1;
        checkOutput({name, "/data0"}, 64'(busB.readData[31:0]), 64'(d0));
        checkOutput({name, "/busy0"}, 64'(busB.readBusy[0]), 64'(b0));
        checkOutput({name, "/data2"}, 64'(busB.readData[95:64]), 64'(d2));
        checkOutput({name, "/busy2"}, 64'(busB.readBusy[2]), 64'(b2));
        checkOutput({name, "/ready"}, 64'(busB.reserveReady), 64'(rdy));
        @(posedge clk);
        #1;
        checkOutput({name, "/count"}, 64'(busB.pendingCount), 64'(cnt));
        idleB();
    endtask

    initial begin
        //          name       ra0 ra1 we wa wd               re rsa fl  d0               b0  d1               b1  rdy cnt inv
        vecs[0]  = '{"rsv7",    7, 31, N, 0, 64'h0,           Y, 7,  N, 64'h0,           N, 64'h0,           N, Y, 1, N};
        vecs[1]  = '{"busy7",   7, 0,  N, 0, 64'h0,           N, 0,  N, 64'h0,           Y, 64'h0,           N, N, 1, N};
        vecs[2]  = '{"wr7byp",  7, 7,  Y, 7, 64'hDEAD_BEEF,   N, 0,  N, 64'hDEAD_BEEF,   N, 64'hDEAD_BEEF,   N, N, 0, N};
        vecs[3]  = '{"rsv3",    3, 7,  N, 0, 64'h0,           Y, 3,  N, 64'h0,           N, 64'hDEAD_BEEF,   N, Y, 1, N};
        vecs[4]  = '{"waw3",    3, 0,  Y, 3, 64'h11,          Y, 3,  N, 64'h11,          N, 64'h0,           N, N, 0, N};
        vecs[5]  = '{"rd3",     3, 0,  N, 0, 64'h0,           N, 0,  N, 64'h11,          N, 64'h0,           N, N, 0, N};
        vecs[6]  = '{"rsv4",    4, 0,  N, 0, 64'h0,           Y, 4,  N, 64'h0,           N, 64'h0,           N, Y, 1, N};
        vecs[7]  = '{"wr4pend", 4, 0,  Y, 4, 64'h22,          Y, 4,  N, 64'h22,          N, 64'h0,           N, N, 0, N};
        vecs[8]  = '{"wr4free", 4, 0,  Y, 4, 64'h22,          Y, 4,  N, 64'h22,          N, 64'h0,           N, Y, 1, N};
        vecs[9]  = '{"rd4",     4, 0,  N, 0, 64'h0,           N, 0,  N, 64'h22,          Y, 64'h0,           N, N, 1, N};
        vecs[10] = '{"zero",    0, 4,  Y, 0, 64'hFFFF,        Y, 0,  N, 64'h0,           N, 64'h22,          Y, Y, 1, N};
        vecs[11] = '{"rd0",     0, 0,  N, 0, 64'h0,           N, 0,  N, 64'h0,           N, 64'h0,           N, N, 1, Y};
        vecs[12] = '{"rsv1",    1, 0,  N, 0, 64'h0,           Y, 1,  N, 64'h0,           N, 64'h0,           N, Y, 2, N};
        vecs[13] = '{"rsv2",    1, 2,  N, 0, 64'h0,           Y, 2,  N, 64'h0,           Y, 64'h0,           N, Y, 3, N};
        vecs[14] = '{"rsv9",    2, 9,  N, 0, 64'h0,           Y, 9,  N, 64'h0,           Y, 64'h0,           N, Y, 4, Y};
        vecs[15] = '{"flush",   2, 9,  Y, 2, 64'h5,           Y, 10, Y, 64'h5,           N, 64'h0,           Y, N, 0, N};
        vecs[16] = '{"postfl",  2, 9,  N, 0, 64'h0,           N, 0,  N, 64'h5,           N, 64'h0,           N, N, 0, Y};
        vecs[17] = '{"wrfree",  12, 0, Y, 12, 64'hABC,        N, 0,  N, 64'hABC,         N, 64'h0,           N, N, 0, N};
        vecs[18] = '{"rsv13",   12, 7, N, 0, 64'h0,           Y, 13, N, 64'hABC,         N, 64'hDEAD_BEEF,   N, Y, 1, N};

        idleA();
        idleB();
        rst_n = 1'b0;
        busA.readAddr    = {5'd31, 5'd5};
        busA.reserveEn   = 1'b1;
        busA.reserveAddr = 5'd3;
        #1;
        checkOutput("rst/data0", busA.readData[63:0], 64'h0);
        checkOutput("rst/data1", busA.readData[127:64], 64'h0);
        checkOutput("rst/busy", 64'(busA.readBusy), 64'h0);
        checkOutput("rst/count", 64'(busA.pendingCount), 64'h0);
        checkOutput("rst/ready", 64'(busA.reserveReady), 64'h1);
        idleA();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
        end

        //             name       ra0 ra1 ra2 we wa wd          re rsa fl  d0          b0 d2          b2 rdy cnt
        applyStimulusB("b_rsv7",  7, 0, 15, N, 0, 32'h0,      Y, 7, N, 32'h0,      N, 32'h0,      N, Y, 1);
        applyStimulusB("b_wr7",   7, 0, 7,  Y, 7, 32'h1234,   N, 0, N, 32'h0,      Y, 32'h0,      Y, N, 0);
        applyStimulusB("b_rd7",   7, 0, 7,  N, 0, 32'h0,      N, 0, N, 32'h1234,   N, 32'h1234,   N, N, 0);
        applyStimulusB("b_rsv3",  3, 0, 3,  N, 0, 32'h0,      Y, 3, N, 32'h0,      N, 32'h0,      N, Y, 1);
        applyStimulusB("b_waw3",  3, 0, 3,  Y, 3, 32'h11,     Y, 3, N, 32'h0,      Y, 32'h0,      Y, N, 0);
        applyStimulusB("b_rsv5",  5, 0, 5,  N, 0, 32'h0,      Y, 5, N, 32'h0,      N, 32'h0,      N, Y, 1);
        applyStimulusB("b_rsv6",  5, 0, 6,  N, 0, 32'h0,      Y, 6, N, 32'h0,      Y, 32'h0,      N, Y, 2);
        applyStimulusB("b_flush", 6, 0, 5,  Y, 6, 32'h5,      Y, 8, Y, 32'h0,      Y, 32'h0,      Y, N, 0);
        applyStimulusB("b_post",  6, 0, 5,  N, 0, 32'h0,      N, 0, N, 32'h5,      N, 32'h0,      N, N, 0);
        applyStimulusB("b_zero",  0, 0, 3,  Y, 0, 32'hFFFF,   Y, 0, N, 32'h0,      N, 32'h11,     N, Y, 0);
        applyStimulusB("b_rd0",   0, 0, 0,  N, 0, 32'h0,      N, 0, N, 32'h0,      N, 32'h0,      N, N, 0);

        // Reset dropped between edges with a write and a reserve in flight; x13 is pending here.
        @(negedge clk);
        busA.readAddr    = {5'd7, 5'd12};
        busA.writeEn     = 1'b1;
        busA.writeAddr   = 5'd12;
        busA.writeData   = 64'h77;
        busA.reserveEn   = 1'b1;
        busA.reserveAddr = 5'd20;
        #10;
        rst_n = 1'b0;
        #1;
        checkOutput("arst/data0", busA.readData[63:0], 64'h0);
        checkOutput("arst/data1", busA.readData[127:64], 64'h0);
        checkOutput("arst/count", 64'(busA.pendingCount), 64'h0);
        checkOutput("arst/ready", 64'(busA.reserveReady), 64'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        idleA();
        rst_n = 1'b1;
        busA.readAddr = {5'd20, 5'd12};
        #1;
        checkOutput("arst/post_data12", busA.readData[63:0], 64'h0);
        checkOutput("arst/post_busy20", 64'(busA.readBusy[1]), 64'h0);
        checkOutput("arst/post_count", 64'(busA.pendingCount), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
